// File: rtl/croc_pkg.sv
// Shared types and constants for the croc SoC subordinate ports.
// Holds the OBI subordinate request/response shapes, SRAM bank sizing and
// the helper types used by the per-bank SRAM adapter.
package croc_pkg;

    localparam int unsigned SbrObiIdWidth    = 4;
    localparam int unsigned SramBankNumWords = 512;
    localparam logic [31:0] BootAddr         = 32'h1000_0000;

    // Data returned alongside err=1 by an SRAM bank adapter.
    localparam logic [31:0] SramErrData      = 32'hBADC_AB1E;
    // Default SRAM macro read latency in cycles.
    localparam int unsigned SramReadLatency  = 1;

    typedef struct packed {
        logic                     req;
        logic                     we;
        logic [3:0]               be;
        logic [31:0]              addr;
        logic [31:0]              wdata;
        logic [SbrObiIdWidth-1:0] aid;
    } sbr_obi_req_t;

    typedef struct packed {
        logic                     gnt;
        logic                     rvalid;
        logic [31:0]              rdata;
        logic [SbrObiIdWidth-1:0] rid;
        logic                     err;
    } sbr_obi_rsp_t;

    // One queued response travelling through the response pipe.
    typedef struct packed {
        logic                     vld;
        logic [SbrObiIdWidth-1:0] rid;
        logic                     err;
        logic                     is_read;
    } sram_rsp_meta_t;

    typedef enum logic [1:0] {
        SRAM_IDLE,
        SRAM_RMW_WAIT,
        SRAM_RMW_WRITE
    } sram_adapter_state_e;

endpackage

// File: rtl/croc_sram_rsp_pipe.sv
// Response delay line for the SRAM bank adapter.
// Responses enter at the head and emerge Latency cycles later, lined up with
// the SRAM read data. A second entry point drops a response straight into the
// last stage so it emerges on the next cycle (used by the RMW write phase).
module croc_sram_rsp_pipe
    import croc_pkg::*;
#(
    parameter int unsigned Latency = SramReadLatency,
    parameter logic [31:0] ErrData = SramErrData
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  sram_rsp_meta_t           head_i,
    input  sram_rsp_meta_t           late_i,
    input  logic [31:0]              sram_rdata_i,
    output logic                     rvalid_o,
    output logic [31:0]              rdata_o,
    output logic [SbrObiIdWidth-1:0] rid_o,
    output logic                     err_o
);

    localparam int unsigned Last = Latency - 1;

    sram_rsp_meta_t meta_p [Latency];
    sram_rsp_meta_t tail;

    // Shift queued responses one stage per cycle; a late entry lands in the last stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Latency; i++) begin
                meta_p[i] <= '0;
            end
        end else begin
            meta_p[0] <= head_i;
            for (int i = 1; i < Latency; i++) begin
                meta_p[i] <= meta_p[i-1];
            end
            if (late_i.vld) begin
                meta_p[Last] <= late_i;
            end
        end
    end

    assign tail = meta_p[Last];

    // Drive the response fields; everything reads as zero when nothing is valid.
    always_comb begin
        rvalid_o = tail.vld;
        rid_o    = '0;
        err_o    = 1'b0;
        rdata_o  = '0;
        if (tail.vld) begin
            rid_o = tail.rid;
            err_o = tail.err;
            if (tail.err) begin
                rdata_o = ErrData;
            end else if (tail.is_read) begin
                rdata_o = sram_rdata_i;
            end
        end
    end

endmodule

// File: rtl/croc_sram_bank_adapter.sv
// Per-bank OBI subordinate in front of one SRAM macro wrapper.
// Decodes the bank window, issues SRAM strobes combinationally from the
// request, returns responses after a fixed read latency, and emulates byte
// enables with read-modify-write for macros that cannot mask bytes.
module croc_sram_bank_adapter
    import croc_pkg::*;
#(
    parameter int unsigned NumWords      = SramBankNumWords,
    parameter logic [31:0] BaseAddr      = BootAddr,
    parameter int unsigned Latency       = SramReadLatency,
    parameter bit          HasByteEnable = 1'b1,
    parameter logic [31:0] ErrData       = SramErrData,
    localparam int unsigned AW           = $clog2(NumWords)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  sbr_obi_req_t  obi_req_i,
    output sbr_obi_rsp_t  obi_rsp_o,
    output logic          sram_req_o,
    output logic          sram_we_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_wdata_o,
    output logic [3:0]    sram_be_o,
    input  logic [31:0]   sram_rdata_i
);

    if (!(Latency == 1 || Latency == 2)) begin : g_bad_latency
        $error("croc_sram_bank_adapter: Latency must be 1 or 2");
    end

    localparam logic [31:0] RangeBytes = 32'(NumWords * 4);
    localparam logic [1:0]  WaitInit   = 2'(Latency - 1);

    // Byte-wise merge of new write data over the word read back from the macro.
    function automatic logic [31:0] merge_bytes(input logic [31:0] new_word,
                                                input logic [31:0] old_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    sram_adapter_state_e state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;

    logic [31:0]              offset;
    logic                     in_range;
    logic [AW-1:0]            word_idx;
    logic                     accept;
    logic                     needs_rmw;
    logic                     capture;

    logic [31:0]              rmw_wdata_q;
    logic [3:0]               rmw_be_q;
    logic [SbrObiIdWidth-1:0] rmw_aid_q;
    logic [AW-1:0]            rmw_idx_q;

    sram_rsp_meta_t           head, late;
    logic                     pipe_rvalid, pipe_err;
    logic [31:0]              pipe_rdata;
    logic [SbrObiIdWidth-1:0] pipe_rid;

    // Wrapping subtraction makes addresses below the base land far out of range.
    assign offset   = obi_req_i.addr - BaseAddr;
    assign in_range = offset < RangeBytes;
    assign word_idx = offset[AW+1:2];
    assign accept   = obi_req_i.req && (state_q == SRAM_IDLE) && !rst_i;
    assign needs_rmw = !HasByteEnable && obi_req_i.we && in_range
                       && (obi_req_i.be != 4'hF) && (obi_req_i.be != 4'h0);

    // State and latency counter; reset abandons any RMW in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SRAM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hold the pending sub-word write while the old word is read back.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            rmw_wdata_q <= obi_req_i.wdata;
            rmw_be_q    <= obi_req_i.be;
            rmw_aid_q   <= obi_req_i.aid;
            rmw_idx_q   <= word_idx;
        end
    end

    // Next state, SRAM strobes and response enqueueing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture      = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        head         = '0;
        late         = '0;

        case (state_q)
            SRAM_IDLE: begin
                if (accept) begin
                    head.vld = 1'b1;
                    head.rid = obi_req_i.aid;
                    if (!in_range) begin
                        head.err = 1'b1;
                    end else if (!obi_req_i.we) begin
                        sram_req_o  = 1'b1;
                        sram_addr_o = word_idx;
                        sram_be_o   = HasByteEnable ? obi_req_i.be : 4'hF;
                        head.is_read = 1'b1;
                    end else if (needs_rmw) begin
                        head        = '0;
                        sram_req_o  = 1'b1;
                        sram_addr_o = word_idx;
                        sram_be_o   = 4'hF;
                        capture     = 1'b1;
                        cnt_d       = WaitInit;
                        state_d     = (Latency > 1) ? SRAM_RMW_WAIT : SRAM_RMW_WRITE;
                    end else begin
                        // A macro without byte masking cannot honour be=0, so that
                        // write degrades to a harmless read strobe there.
                        sram_req_o   = 1'b1;
                        sram_we_o    = HasByteEnable || (obi_req_i.be != 4'h0);
                        sram_addr_o  = word_idx;
                        sram_wdata_o = obi_req_i.wdata;
                        sram_be_o    = HasByteEnable ? obi_req_i.be : 4'hF;
                    end
                end
            end
            SRAM_RMW_WAIT: begin
                if (cnt_q <= 2'd1) begin
                    state_d = SRAM_RMW_WRITE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            SRAM_RMW_WRITE: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = rmw_idx_q;
                sram_wdata_o = merge_bytes(rmw_wdata_q, sram_rdata_i, rmw_be_q);
                sram_be_o    = 4'hF;
                late.vld     = 1'b1;
                late.rid     = rmw_aid_q;
                state_d      = SRAM_IDLE;
            end
            default: begin
                state_d = SRAM_IDLE;
            end
        endcase
    end

    croc_sram_rsp_pipe #(
        .Latency (Latency),
        .ErrData (ErrData)
    ) i_rsp_pipe (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .head_i       (head),
        .late_i       (late),
        .sram_rdata_i (sram_rdata_i),
        .rvalid_o     (pipe_rvalid),
        .rdata_o      (pipe_rdata),
        .rid_o        (pipe_rid),
        .err_o        (pipe_err)
    );

    // Assemble the OBI response; grant only while idle.
    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = (state_q == SRAM_IDLE);
        obi_rsp_o.rvalid = pipe_rvalid;
        obi_rsp_o.rdata  = pipe_rdata;
        obi_rsp_o.rid    = pipe_rid;
        obi_rsp_o.err    = pipe_err;
    end

endmodule

// File: doc/croc_sram_bank_adapter.md
# croc_sram_bank_adapter

Per-bank OBI subordinate that sits directly downstream of the main crossbar on each `XbarBank0+n` port and drives one SRAM macro wrapper. It accepts `croc_pkg::sbr_obi_req_t` and returns `croc_pkg::sbr_obi_rsp_t` with a fixed, parameterised read latency. Out-of-bank addresses receive an OBI error response. For macros without byte enables it performs sub-word writes as read-modify-write sequences.

## Interface

**Parameters**
- `NumWords`, default `croc_pkg::SramBankNumWords` (512): words per bank. AW = $clog2(NumWords).
- `BaseAddr`, default `croc_pkg::BootAddr`: first byte address of this bank.
- `Latency`, default 1: SRAM read latency in cycles. Legal values are 1 or 2; any other value is an elaboration error.
- `HasByteEnable`, default 1'b1: 1 means the macro honours `sram_be_o`; 0 means the adapter emulates byte enables with read-modify-write (RMW).
- `ErrData`, default 32'hBADC_AB1E: rdata returned with err.

**Ports**
- `clk_i` (in, 1): clock.
- `rst_i` (in, 1): reset. One clock; reset is asynchronous and active-high.
- `obi_req_i` (in, `sbr_obi_req_t`): OBI request from the crossbar.
- `obi_rsp_o` (out, `sbr_obi_rsp_t`): OBI response (gnt, rvalid, rdata, rid, err).
- `sram_req_o` (out, 1): SRAM access strobe.
- `sram_we_o` (out, 1): SRAM write enable.
- `sram_addr_o` (out, AW): SRAM word index.
- `sram_wdata_o` (out, 32): SRAM write data.
- `sram_be_o` (out, 4): SRAM byte enables. Forced to 4'hF when HasByteEnable=0.
- `sram_rdata_i` (in, 32): SRAM read data, valid `Latency` cycles after a read strobe.

## Operation

- Offset = `addr - BaseAddr`, computed in 32-bit arithmetic with wrap-around.
  - In range when offset < NumWords*4.
  - Word index = offset[AW+1:2]. addr[1:0] is ignored.
- **States:** IDLE, RMW_WAIT, RMW_WRITE.
- **Grant:** `gnt` = (state == IDLE). A request is accepted in the cycle where req & gnt.
- **IDLE, accepted request, one of the following:**
  - Out of range: no SRAM strobe. Queue a response with err=1, rdata=ErrData.
  - Read: SRAM read strobe in the same cycle. Queue a response with err=0.
  - Write with HasByteEnable=1, or write with be=4'hF: SRAM write with the request's be. Queue a response with err=0, rdata=0.
  - Write with HasByteEnable=0 and be≠4'hF: SRAM read of the word. Capture wdata, be, aid and index. Go to RMW_WAIT.
- **RMW_WAIT:** count `Latency` cycles, then go to RMW_WRITE.
- **RMW_WRITE:**
  - Write merged data: byte i = be[i] ? wdata byte i : `sram_rdata_i` byte i.
  - Queue a response with err=0, rdata=0, then go to IDLE.
- **be=4'h0 write:** treated as a full-word-path write with no bytes changed. No RMW; SRAM strobe with be=0.
- **rid:** always the aid of the originating request.
- **Reset mid-operation:** FSM returns to IDLE, in-flight responses are dropped, and no spurious SRAM strobe occurs.

## Timing

- **Reset values:**
  - `rvalid`=0, `rdata`=0, `rid`=0, `err`=0.
  - `gnt`=1 (IDLE).
  - `sram_req_o`=0, `sram_we_o`=0, `sram_addr_o`=0, `sram_wdata_o`=0, `sram_be_o`=0.
- SRAM outputs are combinational from `obi_req_i` in IDLE and from captured registers in RMW_WRITE. They are 0 when there is no strobe.
- **Read, write or error accepted at cycle T:** `rvalid` pulses for one cycle at T+Latency.
  - Read: `rdata` = `sram_rdata_i` in that cycle.
- **Back-to-back:** one accept per cycle in IDLE gives one rvalid per cycle, in order. No rready (UseRReady=0), so no backpressure.
- **RMW accepted at cycle T:**
  - Read strobe at T.
  - Write strobe at T+Latency.
  - `rvalid` at T+Latency+1.
  - `gnt` low from T+1 through T+Latency. The next accept is possible at T+Latency+1.
- A response queued in RMW_WRITE never collides with an earlier response, because gnt was low for ≥ Latency cycles.

## Structure

- `croc_pkg` already supplies `sbr_obi_req_t`, `sbr_obi_rsp_t` and `SramBankNumWords`.
- Add to `croc_pkg`:
  - `SramErrData` (32'hBADC_AB1E).
  - `SramReadLatency` (1).
- One sub-module, `croc_sram_rsp_pipe`:
  - `Latency`-deep shift register of {valid, rid, err, is_read}.
  - Muxes rdata among `sram_rdata_i`, 0 and ErrData at the output.
- The FSM and merge logic live in the top module.

## Test plan

1. **Read after write, Latency=1:** write 32'hDEAD_BEEF (be=F) to BaseAddr+0x10, aid=3, then read it back → write rvalid next cycle with rdata=0, err=0, rid=3; read rvalid next cycle with rdata=32'hDEAD_BEEF.
2. **Out of range:** read at BaseAddr+NumWords*4 and at BaseAddr-4 → no `sram_req_o`; rvalid at T+1 with err=1, rdata=32'hBADC_AB1E.
3. **RMW, HasByteEnable=0, Latency=2:** word holds 32'h1122_3344; write wdata 32'hAABB_CCDD with be=4'b0101 → `gnt` low for 2 cycles; SRAM write of 32'h11BB_33DD with be=F at T+2; rvalid at T+3.
4. **Streaming, Latency=2:** 8 back-to-back reads with alternating rid → 8 consecutive rvalid cycles from T+2, in order, rids matching.
5. **Reset mid-RMW:** assert `rst_i` at T+1 of an RMW → no write strobe, no rvalid, `gnt`=1 after release; a following read returns the original data.
